ldpc_iter_ctrl: RTL and testbench



---
 rtl/ldpc_iter_ctrl_if.sv | 26 ++
 rtl/ldpc_iter_ctrl.sv | 94 +++++++++
 tb/tb_ldpc_iter_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_iter_ctrl_if.sv
// rtl/ldpc_iter_ctrl_if.sv - frame handshake, syndrome status and datapath enable bundle
interface ldpc_iter_ctrl_if #(
    parameter int ADDR_W = 2,
    parameter int ITER_W = 4
);
    logic              start;
    logic              syn_ok;
    logic              busy;
    logic              done;
    logic              load_en;
    logic              cnu_en;
    logic              vnu_en;
    logic [ADDR_W-1:0] blk_addr;
    logic [ITER_W-1:0] iter_cnt;
    logic              converged;

    modport master (
        output start, syn_ok,
        input  busy, done, load_en, cnu_en, vnu_en, blk_addr, iter_cnt, converged
    );

    modport slave (
        input  start, syn_ok,
        output busy, done, load_en, cnu_en, vnu_en, blk_addr, iter_cnt, converged
    );
endinterface

// File: rtl/ldpc_iter_ctrl.sv
// rtl/ldpc_iter_ctrl.sv - LDPC iteration sequencer: LOAD, then CNU/VNU/CHK until convergence or MAX_ITER
// Optional early termination on syndrome pass: define LDPC_EARLY_TERM_EN.
module ldpc_iter_ctrl #(
    parameter int N_BLK    = 4,
    parameter int ADDR_W   = 2,
    parameter int MAX_ITER = 8,
    parameter int ITER_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ldpc_iter_ctrl_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CNU,
        S_VNU,
        S_CHK,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_BLK  = ADDR_W'(N_BLK - 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_blk;
    logic [ITER_W-1:0] r_iter;
    logic              r_conv;
    logic              w_term;
    logic              w_blk_last;

`ifdef LDPC_EARLY_TERM_EN
    assign w_term = bus.syn_ok;
`else
    assign w_term = 1'b0;
`endif

    assign w_blk_last = (r_blk == LAST_BLK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_blk   <= '0;
            r_iter  <= '0;
            r_conv  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LOAD;
                        r_blk   <= '0;
                        r_iter  <= '0;
                        r_conv  <= 1'b0;
                    end
                end
                S_LOAD, S_CNU, S_VNU: begin
                    if (w_blk_last) begin
                        r_blk <= '0;
                        case (r_state)
                            S_LOAD:  r_state <= S_CNU;
                            S_CNU:   r_state <= S_VNU;
                            default: r_state <= S_CHK;
                        endcase
                    end else begin
                        r_blk <= r_blk + 1'b1;
                    end
                end
                S_CHK: begin
                    r_iter  <= r_iter + 1'b1;
                    r_conv  <= bus.syn_ok;
                    // r_iter still holds the pre-increment count here
                    r_state <= (w_term || r_iter == LAST_ITER) ? S_DONE : S_CNU;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_blk   <= '0;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state == S_LOAD) || (r_state == S_CNU) ||
                           (r_state == S_VNU)  || (r_state == S_CHK);
    assign bus.done      = (r_state == S_DONE);
    assign bus.load_en   = (r_state == S_LOAD);
    assign bus.cnu_en    = (r_state == S_CNU);
    assign bus.vnu_en    = (r_state == S_VNU);
    assign bus.blk_addr  = r_blk;
    assign bus.iter_cnt  = r_iter;
    assign bus.converged = r_conv;
endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb/tb_ldpc_iter_ctrl.sv - randomized self-checking bench for ldpc_iter_ctrl against a timeline model
module tb_ldpc_iter_ctrl;
    localparam int N   = 4;
    localparam int MI  = 3;
    localparam int PER = 2 * N + 1;
`ifdef LDPC_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ldpc_iter_ctrl_if #(.ADDR_W(2), .ITER_W(4)) bus ();

    ldpc_iter_ctrl #(.N_BLK(N), .ADDR_W(2), .MAX_ITER(MI), .ITER_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a timeline t counted from E0, phases derived arithmetically.
    bit m_active = 0;
    bit m_dpulse = 0;
    bit m_conv   = 0;
    int m_t      = 0;
    int m_iter   = 0;
    int cyc      = 0;
    int e0       = 0;
    int kk;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 0; m_dpulse = 0; m_t = 0; m_iter = 0; m_conv = 0;
        end else begin
            cyc++;
            if (m_dpulse) begin
                m_dpulse = 0;
            end else if (!m_active) begin
                if (bus.start) begin
                    m_active = 1; m_t = 0; m_iter = 0; m_conv = 0; e0 = cyc;
                end
            end else if (m_t >= N && (m_t - N) % PER == 2 * N) begin
                kk     = (m_t - N) / PER + 1;
                m_iter = kk;
                m_conv = bus.syn_ok;
                if ((EARLY && bus.syn_ok) || kk == MI) begin
                    m_active = 0;
                    m_dpulse = 1;
                end else begin
                    m_t++;
                end
            end else begin
                m_t++;
            end
        end
    end

    logic e_busy, e_done, e_load, e_cnu, e_vnu;
    int   e_addr, rr;
    int   n_done = 0, done_k = -1;
    int   c_load = 0, c_cnu = 0, c_vnu = 0;

    initial forever begin
        @(negedge clk);
        e_busy = 0; e_done = 0; e_load = 0; e_cnu = 0; e_vnu = 0; e_addr = 0;
        if (m_dpulse) begin
            e_done = 1;
        end else if (m_active) begin
            e_busy = 1;
            if (m_t < N) begin
                e_load = 1; e_addr = m_t;
            end else begin
                rr = (m_t - N) % PER;
                if (rr < N) begin
                    e_cnu = 1; e_addr = rr;
                end else if (rr < 2 * N) begin
                    e_vnu = 1; e_addr = rr - N;
                end
            end
        end
        chk("busy",      32'(bus.busy),      32'(e_busy));
        chk("done",      32'(bus.done),      32'(e_done));
        chk("load_en",   32'(bus.load_en),   32'(e_load));
        chk("cnu_en",    32'(bus.cnu_en),    32'(e_cnu));
        chk("vnu_en",    32'(bus.vnu_en),    32'(e_vnu));
        chk("blk_addr",  32'(bus.blk_addr),  32'(e_addr));
        chk("iter_cnt",  32'(bus.iter_cnt),  32'(m_iter));
        chk("converged", 32'(bus.converged), 32'(m_conv));
        chk("en_excl", 32'((32'(bus.load_en) + 32'(bus.cnu_en) + 32'(bus.vnu_en)) <= 1), 32'd1);
        if (bus.done === 1'b1) begin
            n_done++;
            done_k = cyc - e0;
        end
        if (bus.load_en === 1'b1) c_load++;
        if (bus.cnu_en  === 1'b1) c_cnu++;
        if (bus.vnu_en  === 1'b1) c_vnu++;
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        bit got;
        got = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1;
                break;
            end
        end
        chk("done_timeout", 32'(got), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_t(input int t, input int lim);
        bit got;
        got = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (m_active && m_t == t) begin
                got = 1;
                break;
            end
        end
        chk("phase_timeout", 32'(got), 32'd1);
    endtask

    int l0, cn0, v0, nd0;

    initial begin
        bus.start  = 1'b0;
        bus.syn_ok = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_addr", 32'(bus.blk_addr), 32'd0);
        chk("rst_iter", 32'(bus.iter_cnt), 32'd0);
        chk("rst_conv", 32'(bus.converged), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // full run without convergence
        bus.syn_ok = 1'b0;
        l0 = c_load; cn0 = c_cnu; v0 = c_vnu;
        pulse_start();
        wait_done(100);
        chk("full_done_edge", 32'(done_k), 32'd31);
        chk("full_iter", 32'(bus.iter_cnt), 32'd3);
        chk("full_conv", 32'(bus.converged), 32'd0);
        chk("cnt_load", 32'(c_load - l0), 32'd4);
        chk("cnt_cnu", 32'(c_cnu - cn0), 32'd12);
        chk("cnt_vnu", 32'(c_vnu - v0), 32'd12);

        // syndrome passes at the first check
        bus.syn_ok = 1'b1;
        pulse_start();
        wait_done(100);
        chk("early_done_edge", 32'(done_k), EARLY ? 32'd13 : 32'd31);
        chk("early_iter", 32'(bus.iter_cnt), EARLY ? 32'd1 : 32'd3);
        chk("early_conv", 32'(bus.converged), 32'd1);
        bus.syn_ok = 1'b0;

        // start pulses during CNU and DONE are ignored
        pulse_start();
        wait_t(N + 1, 50);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("ign_busy", 32'(bus.busy), 32'd0);
        chk("ign_done_edge", 32'(done_k), 32'd31);
        chk("ign_iter", 32'(bus.iter_cnt), 32'd3);
        pulse_start();
        wait_done(100);
        chk("after_ign_edge", 32'(done_k), 32'd31);

        // asynchronous reset in the second VNU cycle
        pulse_start();
        wait_t(2 * N + 1, 50);
        nd0 = n_done;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_done", 32'(bus.done), 32'd0);
        chk("ar_load", 32'(bus.load_en), 32'd0);
        chk("ar_cnu", 32'(bus.cnu_en), 32'd0);
        chk("ar_vnu", 32'(bus.vnu_en), 32'd0);
        chk("ar_conv", 32'(bus.converged), 32'd0);
        chk("ar_addr", 32'(bus.blk_addr), 32'd0);
        chk("ar_iter", 32'(bus.iter_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("ar_no_done", 32'(n_done - nd0), 32'd0);
        pulse_start();
        wait_done(100);
        chk("ar_restart_edge", 32'(done_k), 32'd31);

        // randomized frames: syndrome, stray starts and idle gaps
        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_start();
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (bus.done === 1'b1) break;
                bus.syn_ok = ($urandom % 4 == 0);
                bus.start  = ($urandom % 8 == 0);
            end
            bus.start  = 1'b0;
            bus.syn_ok = 1'b0;
            repeat (2) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
